mouse_receiver: RTL and testbench
=================================

// Module: mouse_receiver
// PURPOSE
//  PS/2 device-to-host byte receiver; upstream stage of the mouse transceiver/master SM feeding the bus peripheral.
//  Samples the open-drain CLK_MOUSE/DATA_MOUSE lines and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop).
//  Delivers each byte with error flags as a one-cycle BYTE_READY strobe; the master SM assembles status/X/Y packets from these.
// PARAMETERS
//  SYNC_STAGES     2      flops in synchroniser for CLK_MOUSE_IN and DATA_MOUSE_IN (>=2)
//  FILTER_LEN      8      consecutive equal synchronised samples needed before the filtered PS/2 clock changes (glitch filter)
//  TIMEOUT_CYCLES  50000  system clocks allowed between PS/2 clock falling edges inside a frame (500 us @ 100 MHz)
// PORTS
//  CLK              in   1  system clock, 100 MHz
//  RESET            in   1  asynchronous, active-high reset
//  CLK_MOUSE_IN     in   1  raw PS/2 clock line level (tristate input side)
//  DATA_MOUSE_IN    in   1  raw PS/2 data line level
//  READ_ENABLE      in   1  master SM permits reception; low = frames ignored
//  BYTE_READ        out  8  received data byte, held until next BYTE_READY
//  BYTE_ERROR_CODE  out  2  [0]=parity error, [1]=stop-bit error; valid with BYTE_READY
//  BYTE_READY       out  1  one-cycle strobe: BYTE_READ/BYTE_ERROR_CODE valid
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; bit count 0; timeout counter 0; filtered clock = 1.
//  Input path: SYNC_STAGES-flop synchroniser, then clock glitch filter (FILTER_LEN equal samples). Falling edge of filtered clock = sample strobe; data sampled on that cycle.
//  Strobe latency: 1 + SYNC_STAGES + FILTER_LEN system clocks after the raw line falls.
//  FSM (advances only on sample strobes, except timeout):
//   IDLE   : strobe with READ_ENABLE=1 and data=0 (start bit) -> DATA, count=0. Data=1 at strobe or READ_ENABLE=0 -> stay IDLE.
//   DATA   : shift data into bit [count] (LSB first); count 7 -> PARITY.
//   PARITY : capture parity bit -> STOP.
//   STOP   : capture stop bit -> DONE.
//   DONE   : one cycle: BYTE_READ <= shift reg; BYTE_ERROR_CODE[0] <= (^data ^ parity)==0 (odd parity fail); [1] <= (stop==0); BYTE_READY=1 -> IDLE.
//  BYTE_READY: high exactly one cycle, the cycle after stop strobe. Errored bytes are still delivered (flags set), master SM decides.
//  Timeout: counter clears on each strobe, increments each cycle in DATA/PARITY/STOP; at TIMEOUT_CYCLES -> IDLE, partial byte discarded, no BYTE_READY, outputs unchanged.
//  READ_ENABLE falling mid-frame: frame completes normally (gating applies only at start bit).
//  Start bit is not re-checked; a missing start is invisible (frame never begins).
//  Async RESET mid-frame: immediate return to reset values; partial byte lost; no strobe.
//  Glitches shorter than FILTER_LEN cycles on clock line: no strobe, no bit consumed.
//  Back-to-back frames: IDLE accepts next start bit on the first strobe after DONE.
// TESTING
//  T1 frame 0xFA, parity 1, stop 1, READ_ENABLE=1 -> one BYTE_READY, BYTE_READ=0xFA, ERROR=2'b00.
//  T2 frame 0x08 with parity 1 (even -> wrong) -> BYTE_READ=0x08, ERROR=2'b01; frame 0x00 parity 1 stop 0 -> ERROR=2'b10.
//  T3 stop PS/2 clock after 4 data bits for 60000 cycles -> no strobe, FSM IDLE; following good 0x55 frame -> BYTE_READ=0x55, ERROR=00.
//  T4 READ_ENABLE=0 during full 0xAA frame -> no BYTE_READY; raise mid-next-frame 0x3C after start bit -> still none; next 0x3C frame -> received.
//  T5 3-cycle low glitches on CLK_MOUSE_IN during 0xC3 frame -> BYTE_READ=0xC3, ERROR=00; assert RESET after bit 5 of a frame -> outputs 0, no strobe.
//  T6 three back-to-back frames 0x08,0x01,0xFF (min 60 us clock period) -> three strobes, values in order, ERROR=00 each.

Source files
------------

// File: rtl/mouse_receiver.sv
// mouse_receiver
//   PS/2 device-to-host byte receiver. Synchronises the raw PS/2 clock and
//   data lines, glitch-filters the clock, and deframes 11-bit frames
//   (start, 8 data LSB-first, odd parity, stop). Each byte is delivered
//   with error flags on a one-cycle BYTE_READY strobe.
// Ports
//   CLK              in   system clock
//   RESET            in   asynchronous active-high reset
//   CLK_MOUSE_IN     in   raw PS/2 clock line level
//   DATA_MOUSE_IN    in   raw PS/2 data line level
//   READ_ENABLE      in   permits a new frame to start (checked at start bit only)
//   BYTE_READ        out  received byte, held until the next BYTE_READY
//   BYTE_ERROR_CODE  out  [0] parity error, [1] stop-bit error
//   BYTE_READY       out  one-cycle strobe, BYTE_READ/BYTE_ERROR_CODE valid
module mouse_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_DONE} state_t;

  // ---------------- input synchronisers ----------------
  // Both lines idle high, so reset the chains to 1 to avoid a fake edge.
  logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
  logic                   w_clk_s, w_data_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], CLK_MOUSE_IN};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], DATA_MOUSE_IN};
    end
  end

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // ---------------- clock glitch filter ----------------
  // The filtered clock only follows the synchronised clock after FILTER_LEN
  // consecutive differing samples; any return to the old level restarts
  // the count. The data bit is captured on the same cycle the filtered
  // clock falls, so r_sdata is valid whenever r_strobe is high.
  logic [FW-1:0] r_filt_cnt;
  logic          r_filt_clk;
  logic          r_strobe;
  logic          r_sdata;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_filt_cnt <= '0;
      r_filt_clk <= 1'b1;
      r_strobe   <= 1'b0;
      r_sdata    <= 1'b1;
    end else begin
      r_strobe <= 1'b0;
      if (w_clk_s == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt_cnt <= '0;
        r_filt_clk <= w_clk_s;
        r_strobe   <= ~w_clk_s;
        r_sdata    <= w_data_s;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // ---------------- frame FSM ----------------
  state_t        r_state, w_next;
  logic [2:0]    r_count;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_timeout;
  logic          w_in_frame, w_timeout, w_capture;

  // A strobe wins over an expiring timeout: the bit arrived in time.
  assign w_timeout = (r_timeout >= TW'(TIMEOUT_CYCLES - 1)) && !r_strobe;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_strobe && READ_ENABLE && !r_sdata) w_next = S_DATA;
      S_DATA:   if (w_timeout)                           w_next = S_IDLE;
                else if (r_strobe && r_count == 3'd7)    w_next = S_PARITY;
      S_PARITY: if (w_timeout)                           w_next = S_IDLE;
                else if (r_strobe)                       w_next = S_STOP;
      S_STOP:   if (w_timeout)                           w_next = S_IDLE;
                else if (r_strobe)                       w_next = S_DONE;
      S_DONE:                                            w_next = S_IDLE;
      default:                                           w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_frame = (r_state == S_DATA) || (r_state == S_PARITY) || (r_state == S_STOP);
    w_capture  = (r_state == S_STOP) && r_strobe;
    BYTE_READY = (r_state == S_DONE);
  end

  // ---------------- datapath ----------------
  // Output registers load on the stop-bit strobe, so they are already
  // valid during the DONE cycle that raises BYTE_READY, and stay untouched
  // by timeouts and ignored frames.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count         <= '0;
      r_shift         <= '0;
      r_parity        <= 1'b0;
      r_timeout       <= '0;
      BYTE_READ       <= '0;
      BYTE_ERROR_CODE <= '0;
    end else begin
      if (r_strobe || !w_in_frame) r_timeout <= '0;
      else                         r_timeout <= r_timeout + 1'b1;

      if (r_state == S_IDLE) r_count <= '0;

      if (r_state == S_DATA && r_strobe) begin
        r_shift[r_count] <= r_sdata;
        r_count          <= r_count + 1'b1;
      end

      if (r_state == S_PARITY && r_strobe) r_parity <= r_sdata;

      if (w_capture) begin
        BYTE_READ          <= r_shift;
        BYTE_ERROR_CODE[0] <= ~(^r_shift ^ r_parity);
        BYTE_ERROR_CODE[1] <= ~r_sdata;
      end
    end
  end

endmodule

// File: tb/tb_mouse_receiver.sv
module tb_mouse_receiver;

  localparam int SYNC    = 2;
  localparam int FILT    = 8;
  localparam int TMO     = 500;
  localparam int HALF    = 40;   // PS/2 half period in system clocks
  localparam int STALL   = 600;  // longer than TMO

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_dat, rd_en;
  logic [7:0] byte_rd;
  logic [1:0] err_code;
  logic       byte_rdy;

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int seen   = 0;

  logic [9:0] exp_q[$];   // {err[1:0], byte[7:0]}

  always #5 clk = ~clk;

  mouse_receiver #(
    .SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk), .RESET(rst),
    .CLK_MOUSE_IN(ps2_clk), .DATA_MOUSE_IN(ps2_dat), .READ_ENABLE(rd_en),
    .BYTE_READ(byte_rd), .BYTE_ERROR_CODE(err_code), .BYTE_READY(byte_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && byte_rdy === 1'b1) begin
      logic [9:0] e;
      seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {22'd0, err_code, byte_rd}, 32'h3ff);
      end else begin
        e = exp_q.pop_front();
        chk("byte", {24'd0, byte_rd}, {24'd0, e[7:0]});
        chk("err",  {30'd0, err_code}, {30'd0, e[9:8]});
      end
    end
  end

  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_clk(10);
      ps2_clk = 1'b0; wait_clk(3); ps2_clk = 1'b1;
      wait_clk(HALF - 13);
    end else begin
      wait_clk(HALF);
    end
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  // nbits: how many of the 11 frame bits to send; raise_at/reset_at: bit
  // index after which READ_ENABLE rises / RESET pulses (-1 = never).
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input int raise_at, input int reset_at,
                            input bit glitch, input bit expect_byte);
    logic [10:0] f;
    logic [1:0]  e;
    f = {stp, par, d, 1'b0};
    e = {~stp, ~(^d ^ par)};
    if (expect_byte) begin
      exp_q.push_back({e, d});
      pushed++;
    end
    for (int i = 0; i < nbits; i++) begin
      send_bit(f[i], glitch);
      if (i == raise_at) rd_en = 1'b1;
      if (i == reset_at) begin
        rst = 1'b1;
        #1;
        chk("rst_byte",  {24'd0, byte_rd}, 32'd0);
        chk("rst_err",   {30'd0, err_code}, 32'd0);
        chk("rst_ready", {31'd0, byte_rdy}, 32'd0);
        wait_clk(3);
        rst = 1'b0;
        break;
      end
    end
    ps2_dat = 1'b1;
    wait_clk(HALF);
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_en = 1'b1;
    wait_clk(5);
    chk("reset_byte",  {24'd0, byte_rd}, 32'd0);
    chk("reset_err",   {30'd0, err_code}, 32'd0);
    chk("reset_ready", {31'd0, byte_rdy}, 32'd0);
    rst = 1'b0;
    wait_clk(20);

    // T1 good frame
    send_frame(8'hFA, 1'b1, 1'b1, 11, -1, -1, 0, 1);
    // T2 parity error, then stop-bit error
    send_frame(8'h08, 1'b1, 1'b1, 11, -1, -1, 0, 1);
    send_frame(8'h00, 1'b1, 1'b0, 11, -1, -1, 0, 1);
    // T3 stall after 4 data bits, then a good frame
    send_frame(8'h55, 1'b1, 1'b1, 5, -1, -1, 0, 0);
    wait_clk(STALL);
    send_frame(8'h55, 1'b1, 1'b1, 11, -1, -1, 0, 1);
    // T4 gated frame; enable after start bit (misaligned, times out); next frame taken
    rd_en = 1'b0;
    send_frame(8'hAA, 1'b1, 1'b1, 11, -1, -1, 0, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 11, 0, -1, 0, 0);
    wait_clk(STALL);
    send_frame(8'h3C, 1'b1, 1'b1, 11, -1, -1, 0, 1);
    // T5 glitched clock, then reset after data bit 5
    send_frame(8'hC3, 1'b1, 1'b1, 11, -1, -1, 1, 1);
    send_frame(8'h5A, 1'b1, 1'b1, 11, -1, 6, 0, 0);
    wait_clk(50);
    // T6 back-to-back frames
    send_frame(8'h08, 1'b0, 1'b1, 11, -1, -1, 0, 1);
    send_frame(8'h01, 1'b0, 1'b1, 11, -1, -1, 0, 1);
    send_frame(8'hFF, 1'b1, 1'b1, 11, -1, -1, 0, 1);
    wait_clk(100);

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("strobe_count", seen, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
